// File: rtl/pulse_tx_if.sv
// Byte handshake between a producer and the pulse transmitter.
// dav_ is an active-low strobe; rfd flags an idle transmitter.
interface pulse_tx_if;
  logic [7:0] data;
  logic       dav_;
  logic       rfd;

  modport master (
    output data,
    output dav_,
    input  rfd
  );

  modport slave (
    input  data,
    input  dav_,
    output rfd
  );
endinterface

// File: rtl/pulse_tx.sv
// Pulse-width serial transmitter: each bit is a space pulse
// (short = 1, long = 0) followed by a fixed mark gap, LSB first.
module pulse_tx #(
  parameter int SHORT_LEN = 4,
  parameter int LONG_LEN  = 13,
  parameter int GAP_LEN   = 20
) (
  input  logic       clock,
  input  logic       reset,
  pulse_tx_if.slave  bus,
  output logic       txd
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SPACE = 2'd1;
  localparam logic [1:0] MARK  = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  // counters hold remaining cycles minus one
  localparam logic [7:0] SHORT_CNT = 8'(SHORT_LEN - 1);
  localparam logic [7:0] LONG_CNT  = 8'(LONG_LEN - 1);
  localparam logic [7:0] GAP_CNT   = 8'(GAP_LEN - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic       rfd;

  function automatic logic [7:0] pulse_cnt(input logic b);
    return b ? SHORT_CNT : LONG_CNT;
  endfunction

  assign bus.rfd = rfd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      txd   <= 1'b1;
      rfd   <= 1'b1;
      idx   <= 3'd0;
      cnt   <= 8'd0;
      shreg <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.dav_) begin
            shreg <= bus.data;
            idx   <= 3'd0;
            cnt   <= pulse_cnt(bus.data[0]);
            txd   <= 1'b0;
            rfd   <= 1'b0;
            state <= SPACE;
          end
        end
        SPACE: begin
          if (cnt == 8'd0) begin
            cnt   <= GAP_CNT;
            txd   <= 1'b1;
            state <= MARK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        MARK: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (idx == 3'd7) begin
            state <= WAIT;
          end else begin
            idx   <= idx + 3'd1;
            shreg <= shreg >> 1;
            cnt   <= pulse_cnt(shreg[1]);
            txd   <= 1'b0;
            state <= SPACE;
          end
        end
        WAIT: begin
          if (bus.dav_) begin
            rfd   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_tx.sv
// Directed bench: stimulus queues expected pulses and bytes,
// a line monitor decodes txd and checks them independently.
module tb_pulse_tx;

  localparam int SHORT = 4;
  localparam int LONG  = 13;
  localparam int GAP   = 20;

  logic clock = 1'b0;
  logic reset;
  logic txd;

  pulse_tx_if bus ();

  pulse_tx #(
    .SHORT_LEN (SHORT),
    .LONG_LEN  (LONG),
    .GAP_LEN   (GAP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .txd   (txd)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  int   exp_len[$];
  logic [7:0] exp_byte[$];
  int   rx_sum = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  function automatic int plen(input logic [7:0] d, input int i);
    return d[i] ? SHORT : LONG;
  endfunction

  function automatic int frame_len(input logic [7:0] d);
    int s = 8 * GAP;
    for (int i = 0; i < 8; i++) s += plen(d, i);
    return s;
  endfunction

  // line monitor: pulse widths, gaps, decoded bytes
  int   low_run  = 0;
  int   high_run = 0;
  int   npulse   = 0;
  logic prev     = 1'b1;
  logic [7:0] rx_byte = 8'd0;

  always begin
    @(posedge clock);
    #1;
    if (reset) begin
      low_run  = 0;
      high_run = 0;
      npulse   = 0;
      rx_byte  = 8'd0;
      prev     = 1'b1;
    end else begin
      if (txd == 1'b0) begin
        if (prev && npulse > 0 && npulse < 8)
          chk("gap_len", high_run, GAP);
        low_run++;
      end else begin
        if (!prev) begin
          if (exp_len.size() == 0)
            chk("unexpected_pulse", low_run, 0);
          else
            chk("pulse_len", low_run, exp_len.pop_front());
          rx_byte = {(low_run < (SHORT + LONG + 1) / 2), rx_byte[7:1]};
          npulse++;
          if (npulse == 8) begin
            if (exp_byte.size() == 0)
              chk("unexpected_byte", int'(rx_byte), -1);
            else
              chk("rx_byte", int'(rx_byte), int'(exp_byte.pop_front()));
            rx_sum += int'(rx_byte);
            npulse = 0;
          end
          low_run  = 0;
          high_run = 0;
        end
        high_run++;
      end
      prev = txd;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_len.push_back(plen(d, i));
    exp_byte.push_back(d);
  endtask

  // assumes caller is mid-cycle; dav_ pulses low for one edge
  task automatic send(input logic [7:0] d);
    int k;
    push_byte(d);
    bus.data = d;
    bus.dav_ = 1'b0;
    @(posedge clock);
    #1;
    chk("accept_rfd", int'(bus.rfd), 0);
    chk("accept_txd", int'(txd), 0);
    bus.dav_ = 1'b1;
    bus.data = ~d;
    k = 0;
    do begin
      @(posedge clock);
      #1;
      k++;
    end while (!bus.rfd && k < 400);
    chk("frame_len", k, frame_len(d) + 1);
  endtask

  initial begin
    int bad_rfd;
    reset    = 1'b1;
    bus.dav_ = 1'b0;
    bus.data = 8'hFF;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      chk("reset_txd", int'(txd), 1);
      chk("reset_rfd", int'(bus.rfd), 1);
    end
    reset = 1'b0;
    send(8'hFF);
    send(8'h00);
    send(8'h72);

    // dav_ held low through the whole frame and WAIT
    push_byte(8'hA5);
    bus.data = 8'hA5;
    bus.dav_ = 1'b0;
    bad_rfd  = 0;
    for (int i = 0; i < frame_len(8'hA5) + 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.rfd) bad_rfd++;
    end
    chk("held_rfd_low", bad_rfd, 0);
    chk("held_txd_idle", int'(txd), 1);
    bus.dav_ = 1'b1;
    @(posedge clock);
    #1;
    chk("wait_exit_rfd", int'(bus.rfd), 1);

    // reset inside the third pulse of 0x00
    exp_len.push_back(LONG);
    exp_len.push_back(LONG);
    bus.data = 8'h00;
    bus.dav_ = 1'b0;
    @(posedge clock);
    #1;
    bus.dav_ = 1'b1;
    repeat (2 * (LONG + GAP) + 4) @(posedge clock);
    #1;
    chk("mid_pulse_txd", int'(txd), 0);
    reset = 1'b1;
    exp_len.delete();
    exp_byte.delete();
    @(posedge clock);
    #1;
    chk("abort_txd", int'(txd), 1);
    chk("abort_rfd", int'(bus.rfd), 1);
    reset = 1'b0;
    send(8'h01);

    // downstream adder model sums decoded bytes
    rx_sum = 0;
    send(8'h05);
    chk("sum_first", rx_sum, 5);
    send(8'h03);
    chk("sum_second", rx_sum, 8);
    chk("sum_no_overflow", int'(rx_sum > 255), 0);

    repeat (5) @(posedge clock);
    #1;
    chk("pulses_left", exp_len.size(), 0);
    chk("bytes_left", exp_byte.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
